// File: rtl/rv_multicycle_ctrl_if.sv
// Instruction-memory request/acknowledge port between the sequencer (master)
// and the instruction memory (slave).
interface rv_multicycle_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for RV32I ALU instructions,
// with a sticky FAULT state for illegal encodings and fetch timeouts.
module rv_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16,
  parameter int          RET_W         = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 halt_req_i,
  rv_multicycle_ctrl_if.master imem,
  output logic [31:0]          ir_o,
  output logic                 rf_rd_en_o,
  output logic                 alu_src_imm_o,
  output logic                 alu_en_o,
  output logic                 rf_we_o,
  output logic [31:0]          pc_o,
  output logic                 retired_o,
  output logic [RET_W-1:0]     ret_count_o,
  output logic                 busy_o,
  output logic                 fault_o,
  output logic [1:0]           fault_code_o
);

  localparam int CW = $clog2(FETCH_TIMEOUT);

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_FAULT
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    ir_q, ir_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic [1:0]     fc_q, fc_d;
  logic [CW-1:0]  wait_q, wait_d;

  logic req_q, req_d, rd_en_q, rd_en_d, src_imm_q, src_imm_d;
  logic alu_en_q, alu_en_d, we_q, we_d, retired_q, retired_d;
  logic busy_q, busy_d, fault_q, fault_d;

  function automatic logic is_legal(input logic [31:0] insn);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = insn[31:25];
    f3 = insn[14:12];
    case (insn[6:0])
      OP_REG:  is_legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      OP_IMM: begin
        case (f3)
          3'd1:    is_legal = (f7 == 7'h00);
          3'd5:    is_legal = (f7 == 7'h00) || (f7 == 7'h20);
          default: is_legal = 1'b1;
        endcase
      end
      default: is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    fc_d    = fc_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE, S_FAULT: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          fc_d    = 2'b00;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        // An ack on the last permitted wait cycle still completes the fetch.
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == CW'(FETCH_TIMEOUT - 1)) begin
          wait_d  = '0;
          fc_d    = 2'b10;
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (is_legal(ir_q)) begin
          state_d = S_EXEC;
        end else begin
          fc_d    = 2'b01;
          state_d = S_FAULT;
        end
      end
      S_EXEC:  state_d = S_WB;
      S_WB: begin
        ret_d   = ret_q + RET_W'(1);
        pc_d    = pc_q + 32'd4;
        state_d = halt_req_i ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered by decoding the state being entered.
  always_comb begin
    req_d     = (state_d == S_FETCH);
    rd_en_d   = (state_d == S_DECODE);
    alu_en_d  = (state_d == S_EXEC);
    retired_d = (state_d == S_WB);
    we_d      = (state_d == S_WB) && (ir_d[11:7] != 5'd0);
    busy_d    = (state_d != S_IDLE) && (state_d != S_FAULT);
    fault_d   = (state_d == S_FAULT);
    src_imm_d = (state_d == S_DECODE || state_d == S_EXEC || state_d == S_WB)
                && (ir_d[6:0] == OP_IMM);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      ret_q     <= '0;
      fc_q      <= 2'b00;
      wait_q    <= '0;
      req_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      src_imm_q <= 1'b0;
      alu_en_q  <= 1'b0;
      we_q      <= 1'b0;
      retired_q <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ret_q     <= ret_d;
      fc_q      <= fc_d;
      wait_q    <= wait_d;
      req_q     <= req_d;
      rd_en_q   <= rd_en_d;
      src_imm_q <= src_imm_d;
      alu_en_q  <= alu_en_d;
      we_q      <= we_d;
      retired_q <= retired_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign ir_o           = ir_q;
  assign rf_rd_en_o     = rd_en_q;
  assign alu_src_imm_o  = src_imm_q;
  assign alu_en_o       = alu_en_q;
  assign rf_we_o        = we_q;
  assign pc_o           = pc_q;
  assign retired_o      = retired_q;
  assign ret_count_o    = ret_q;
  assign busy_o         = busy_q;
  assign fault_o        = fault_q;
  assign fault_code_o   = fc_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle sequencer for the integer core's register-register and register-immediate ALU instructions. It fetches each instruction over a request/acknowledge instruction-memory port and latches it into the instruction register, which feeds the R-type field decoder. It then steps the register-file read, the ALU and the register-file writeback, and advances the PC. Unsupported encodings and stalled fetches drive it into a sticky fault state.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset and on every start.
FETCH_TIMEOUT, 16, max cycles FETCH waits for imem_ack before faulting (>=2).
RET_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  leave IDLE/FAULT, begin at RESET_PC
halt_req  in  1  sampled in WB; return to IDLE after current instruction
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
ir  out  32  instruction register
rf_rd_en  out  1  register-file read strobe
alu_src_imm  out  1  0: ALU B operand = rs2, 1: sign-extended ir[31:20]
alu_en  out  1  ALU execute strobe
rf_we  out  1  register-file write strobe for rd = ir[11:7]
pc  out  32  current PC
retired  out  1  one-cycle pulse per completed instruction
ret_count  out  RET_W  retired-instruction count
busy  out  1  high in every state except IDLE and FAULT
fault  out  1  high in FAULT
fault_code  out  2  01 illegal instruction, 10 fetch timeout, 00 none

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, FAULT. Moore outputs decoded from the state; all registers use async reset.
- Reset values: state IDLE, pc=RESET_PC, ir=0, ret_count=0, fault_code=00, wait counter 0. All strobes, imem_req, busy and fault are 0. Asserting reset mid-instruction drops imem_req and all strobes immediately (asynchronous) and abandons the instruction.
- IDLE: start -> FETCH with pc<=RESET_PC. imem_ack is ignored.
- FETCH: imem_req=1, imem_addr=pc, both held stable until ack.
  - imem_ack=1: ir<=imem_rdata, wait counter cleared, -> DECODE. An ack in the first FETCH cycle is legal.
  - Otherwise the wait counter increments. If the counter reaches FETCH_TIMEOUT-1 without an ack: -> FAULT, fault_code=10. An ack on that same cycle wins over the timeout.
- DECODE (1 cycle): rf_rd_en=1; legality checked on ir.
  - opcode ir[6:0]=0110011: legal iff funct7 is 0x00, or funct7 is 0x20 with funct3 of 0 or 5. alu_src_imm=0.
  - opcode 0010011: alu_src_imm=1. funct3=1 requires ir[31:25]=0x00. funct3=5 requires ir[31:25] of 0x00 or 0x20. Other funct3 values are always legal.
  - Legal -> EXEC. Any other opcode or an illegal funct combination -> FAULT, fault_code=01.
- alu_src_imm is held from DECODE through WB.
- EXEC (1 cycle): alu_en=1, -> WB.
- WB (1 cycle):
  - rf_we=1 iff ir[11:7]!=0.
  - retired=1; ret_count+=1, wrapping at 2^RET_W.
  - pc<=pc+4, wrapping at 2^32.
  - halt_req=1 -> IDLE, else -> FETCH.
- FAULT: sticky. pc and ir keep the faulting instruction's values and ret_count is frozen. start -> FETCH with pc<=RESET_PC and fault_code cleared. start in any state other than IDLE/FAULT is ignored.
- Latency: 4 cycles per instruction with zero-wait ack (FETCH, DECODE, EXEC, WB), plus 1 cycle per ack wait cycle.

Test Plan:
1. Reset, start pulse, imem_ack on first request, imem_rdata=32'h003100B3 (add x1,x2,x3) -> states FETCH/DECODE/EXEC/WB; rf_we=1 in cycle 4; retired pulse; pc=0x4; ret_count=1.
2. Instruction 32'h00500013 (addi x0,x0,5) -> alu_src_imm=1, rf_we stays 0 in WB, retired=1, pc+=4.
3. Instruction 32'h0000007F -> FAULT after DECODE, fault=1, fault_code=01, pc unchanged; a later start -> FETCH at RESET_PC with fault_code=00.
4. FETCH_TIMEOUT=16, imem_ack held low -> imem_addr stable for 16 cycles, then FAULT with fault_code=10. Separate run with ack on the 16th cycle -> DECODE, no fault.
5. Three back-to-back legal instructions, halt_req=1 during the third WB -> pc=0xC, ret_count=3, IDLE, busy=0, imem_req=0.
6. reset asserted mid-FETCH with an ack pending -> imem_req=0 in the same cycle, pc=RESET_PC, ir=0, state IDLE after release.
